// File: rtl/a2k_pkg.sv
// Shared encodings for the multicycle sequencer: state codes, opcodes,
// ALU operation codes, PC mux selects and the decoded instruction class.
package a2k_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100001;
    localparam logic [5:0] OP_SW    = 6'b100010;
    localparam logic [5:0] OP_ORI   = 6'b100011;
    localparam logic [5:0] OP_ANDI  = 6'b100100;
    localparam logic [5:0] OP_BEQ   = 6'b100101;
    localparam logic [5:0] OP_BNE   = 6'b100110;
    localparam logic [5:0] OP_J     = 6'b111111;

    localparam logic [2:0] ALU_R    = 3'b000;
    localparam logic [2:0] ALU_ADDI = 3'b001;
    localparam logic [2:0] ALU_ANDI = 3'b010;
    localparam logic [2:0] ALU_ORI  = 3'b011;
    localparam logic [2:0] ALU_SW   = 3'b100;
    localparam logic [2:0] ALU_LW   = 3'b101;
    localparam logic [2:0] ALU_BEQ  = 3'b110;
    localparam logic [2:0] ALU_BNE  = 3'b111;
    localparam logic [2:0] ALU_NONE = 3'b000;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_ORI,
        CLS_ANDI,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_ILL
    } op_class_e;

    // Classes whose second ALU operand is the immediate field.
    function automatic logic uses_imm(input op_class_e cls);
        return (cls == CLS_ADDI) || (cls == CLS_ORI) || (cls == CLS_ANDI) ||
               (cls == CLS_LW)   || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/a2k_opdecode.sv
// Combinational opcode decoder: instruction class, ALU operation and an
// illegal-opcode flag.
module a2k_opdecode
    import a2k_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_e  op_class,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        op_class = CLS_ILL;
        alu_op   = ALU_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin op_class = CLS_R;    alu_op = ALU_R;    end
            OP_ADDI:  begin op_class = CLS_ADDI; alu_op = ALU_ADDI; end
            OP_LW:    begin op_class = CLS_LW;   alu_op = ALU_LW;   end
            OP_SW:    begin op_class = CLS_SW;   alu_op = ALU_SW;   end
            OP_ORI:   begin op_class = CLS_ORI;  alu_op = ALU_ORI;  end
            OP_ANDI:  begin op_class = CLS_ANDI; alu_op = ALU_ANDI; end
            OP_BEQ:   begin op_class = CLS_BEQ;  alu_op = ALU_BEQ;  end
            OP_BNE:   begin op_class = CLS_BNE;  alu_op = ALU_BNE;  end
            OP_J:     begin op_class = CLS_J;    alu_op = ALU_NONE; end
            default:  begin op_class = CLS_ILL;  alu_op = ALU_NONE; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes,
// memory stall watchdog, sticky fault flags and a retired-instruction counter.
module multicycle_sequencer
    import a2k_pkg::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             regdst,
    output logic             regwrite,
    output logic             memtoreg,
    output logic             alusrc,
    output logic [1:0]       pc_src,
    output logic [2:0]       ALUop,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_LIMIT - 1);

    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              run_q, run_d;
    logic              enter_fetch;
    logic              stall_hit;

    logic [5:0]        dec_op;
    op_class_e         dec_cls;
    logic [2:0]        dec_alu;
    logic              dec_illegal;

    // DECODE acts on the live opcode; later states use the latched copy.
    assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

    a2k_opdecode u_opdecode (
        .opcode   (dec_op),
        .op_class (dec_cls),
        .alu_op   (dec_alu),
        .illegal  (dec_illegal)
    );

    // A stall on the last allowed cycle trips the watchdog; ready still wins.
    assign stall_hit = !mem_ready && (wait_q >= WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        run_d       = 1'b1;
        enter_fetch = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    if (mem_ready) begin
                        state_d = ST_DECODE;
                    end else if (stall_hit) begin
                        state_d   = ST_HALT;
                        bus_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (dec_illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (dec_cls == CLS_J) begin
                    enter_fetch = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (dec_cls)
                    CLS_BEQ, CLS_BNE: enter_fetch = 1'b1;
                    CLS_LW, CLS_SW: begin
                        state_d = ST_MEM;
                        wait_d  = '0;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (dec_cls == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        enter_fetch = 1'b1;
                    end
                end else if (stall_hit) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB:   enter_fetch = 1'b1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        if (enter_fetch) begin
            state_d = ST_FETCH;
            wait_d  = '0;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            op_q      <= OP_RTYPE;
            wait_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            run_q     <= run_d;
        end
    end

    // Strobes react within the cycle to mem_ready and zero, so they are
    // decoded from the registered state rather than registered themselves.
    always_comb begin
        pc_write = 1'b0;
        ir_write = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        alusrc   = 1'b0;
        pc_src   = PC_SRC_INC;
        ALUop    = ALU_NONE;
        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_INC;
                    end
                end
            end
            ST_DECODE: begin
                if (!dec_illegal && dec_cls == CLS_J) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JMP;
                end
            end
            ST_EXEC: begin
                ALUop  = dec_alu;
                alusrc = uses_imm(dec_cls);
                if (dec_cls == CLS_BEQ) begin
                    pc_write = zero;
                    pc_src   = PC_SRC_BR;
                end else if (dec_cls == CLS_BNE) begin
                    pc_write = !zero;
                    pc_src   = PC_SRC_BR;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (dec_cls == CLS_SW);
                ALUop   = dec_alu;
                alusrc  = uses_imm(dec_cls);
            end
            ST_WB: begin
                regwrite = 1'b1;
                regdst   = (dec_cls == CLS_R);
                memtoreg = (dec_cls == CLS_LW);
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;
    assign halted      = (state_q == ST_HALT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle expected output vectors
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_req, mem_we;
    logic        regdst, regwrite, memtoreg, alusrc;
    logic [1:0]  pc_src;
    logic [2:0]  ALUop;
    logic [2:0]  state;
    logic        illegal, bus_err, halted;
    logic [15:0] instr_count;

    multicycle_sequencer #(.STALL_LIMIT(16), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .memtoreg    (memtoreg),
        .alusrc      (alusrc),
        .pc_src      (pc_src),
        .ALUop       (ALUop),
        .state       (state),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .halted      (halted),
        .instr_count (instr_count)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe patterns {pc_write, ir_write, mem_req, mem_we, regdst, regwrite, memtoreg, alusrc}.
    localparam logic [7:0] S_NONE   = 8'b0000_0000;
    localparam logic [7:0] S_F_OK   = 8'b1110_0000;
    localparam logic [7:0] S_F_WAIT = 8'b0010_0000;
    localparam logic [7:0] S_PCW    = 8'b1000_0000;
    localparam logic [7:0] S_IMM    = 8'b0000_0001;
    localparam logic [7:0] S_MEM_LD = 8'b0010_0001;
    localparam logic [7:0] S_MEM_ST = 8'b0011_0001;
    localparam logic [7:0] S_WB_R   = 8'b0000_1100;
    localparam logic [7:0] S_WB_I   = 8'b0000_0100;
    localparam logic [7:0] S_WB_LD  = 8'b0000_0110;
    // Flags {illegal, bus_err, halted}.
    localparam logic [2:0] F_OK  = 3'b000;
    localparam logic [2:0] F_ILL = 3'b101;
    localparam logic [2:0] F_BUS = 3'b011;

    // Scoreboard.
    logic [34:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [34:0] mon_exp;
    logic [34:0] mon_act;
    string       mon_name;

    function automatic logic [34:0] ev(input logic [2:0] st, input logic [7:0] s,
                                       input logic [1:0] pcs, input logic [2:0] alu,
                                       input logic [2:0] flt, input logic [15:0] c);
        return {st, s, pcs, alu, flt, c};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {state, pc_write, ir_write, mem_req, mem_we, regdst, regwrite,
                        memtoreg, alusrc, pc_src, ALUop, illegal, bus_err, halted, instr_count};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got st=%0d strb=%b pcs=%b alu=%b flt=%b cnt=%0d, expected st=%0d strb=%b pcs=%b alu=%b flt=%b cnt=%0d",
                         mon_name, mon_act[34:32], mon_act[31:24], mon_act[23:22], mon_act[21:19],
                         mon_act[18:16], mon_act[15:0], mon_exp[34:32], mon_exp[31:24],
                         mon_exp[23:22], mon_exp[21:19], mon_exp[18:16], mon_exp[15:0]);
            end
        end
    end

    // Driver tasks: called at posedge+1, drive one cycle and queue its expectation.
    task automatic step(input logic [5:0] op, input logic z, input logic mr,
                        input logic [34:0] exp, input string nm);
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [15:0] c, input string nm);
        step(op, 1'b0, 1'b1, ev(3'd0, S_F_OK, 2'b00, 3'b000, F_OK, c), {nm, "_fetch"});
        step(op, 1'b0, 1'b1, ev(3'd1, S_NONE, 2'b00, 3'b000, F_OK, c), {nm, "_decode"});
    endtask

    task automatic alu_instr(input logic [5:0] op, input logic [2:0] alu, input logic [7:0] ex_s,
                             input logic [7:0] wb_s, input logic [15:0] c, input string nm);
        fetch_decode(op, c, nm);
        step(op, 1'b0, 1'b1, ev(3'd2, ex_s, 2'b00, alu, F_OK, c), {nm, "_exec"});
        step(op, 1'b0, 1'b1, ev(3'd4, wb_s, 2'b00, 3'b000, F_OK, c), {nm, "_wb"});
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        step(6'b000000, 1'b0, 1'b1, ev(3'd0, S_NONE, 2'b00, 3'b000, F_OK, 16'd0), nm);
        rst_n = 1'b1;
        step(6'b000000, 1'b0, 1'b1, ev(3'd0, S_NONE, 2'b00, 3'b000, F_OK, 16'd0), {nm, "_idle"});
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        alu_instr(6'b000000, 3'b000, S_NONE, S_WB_R, 16'd0, "rtype");

        fetch_decode(6'b100001, 16'd1, "lw");
        step(6'b100001, 1'b0, 1'b1, ev(3'd2, S_IMM, 2'b00, 3'b101, F_OK, 16'd1), "lw_exec");
        for (int i = 0; i < 3; i++)
            step(6'b100001, 1'b0, 1'b0, ev(3'd3, S_MEM_LD, 2'b00, 3'b101, F_OK, 16'd1), "lw_mem_wait");
        step(6'b100001, 1'b0, 1'b1, ev(3'd3, S_MEM_LD, 2'b00, 3'b101, F_OK, 16'd1), "lw_mem_ready");
        step(6'b100001, 1'b0, 1'b1, ev(3'd4, S_WB_LD, 2'b00, 3'b000, F_OK, 16'd1), "lw_wb");

        fetch_decode(6'b100101, 16'd2, "beq");
        step(6'b100101, 1'b1, 1'b1, ev(3'd2, S_PCW, 2'b01, 3'b110, F_OK, 16'd2), "beq_exec_taken");
        fetch_decode(6'b100110, 16'd3, "bne");
        step(6'b100110, 1'b1, 1'b1, ev(3'd2, S_NONE, 2'b01, 3'b111, F_OK, 16'd3), "bne_exec_not_taken");

        step(6'b111111, 1'b0, 1'b1, ev(3'd0, S_F_OK, 2'b00, 3'b000, F_OK, 16'd4), "j_fetch");
        step(6'b111111, 1'b0, 1'b1, ev(3'd1, S_PCW, 2'b10, 3'b000, F_OK, 16'd4), "j_decode");

        alu_instr(6'b100000, 3'b001, S_IMM, S_WB_I, 16'd5, "addi");
        alu_instr(6'b100011, 3'b011, S_IMM, S_WB_I, 16'd6, "ori");
        alu_instr(6'b100100, 3'b010, S_IMM, S_WB_I, 16'd7, "andi");

        fetch_decode(6'b100010, 16'd8, "sw");
        step(6'b100010, 1'b0, 1'b1, ev(3'd2, S_IMM, 2'b00, 3'b100, F_OK, 16'd8), "sw_exec");
        step(6'b100010, 1'b0, 1'b1, ev(3'd3, S_MEM_ST, 2'b00, 3'b100, F_OK, 16'd8), "sw_mem");

        fetch_decode(6'b010101, 16'd9, "illegal");
        for (int i = 0; i < 3; i++)
            step(6'b000000, 1'b0, 1'(i % 2), ev(3'd5, S_NONE, 2'b00, 3'b000, F_ILL, 16'd9), "illegal_halt");

        do_reset("reset_clears_halt");
        for (int i = 0; i < 15; i++)
            step(6'b111111, 1'b0, 1'b0, ev(3'd0, S_F_WAIT, 2'b00, 3'b000, F_OK, 16'd0), "fetch_wait");
        step(6'b111111, 1'b0, 1'b1, ev(3'd0, S_F_OK, 2'b00, 3'b000, F_OK, 16'd0), "ready_on_limit_cycle");
        step(6'b111111, 1'b0, 1'b1, ev(3'd1, S_PCW, 2'b10, 3'b000, F_OK, 16'd0), "decode_after_limit");
        for (int i = 0; i < 16; i++)
            step(6'b000000, 1'b0, 1'b0, ev(3'd0, S_F_WAIT, 2'b00, 3'b000, F_OK, 16'd1), "fetch_stall");
        for (int i = 0; i < 2; i++)
            step(6'b000000, 1'b0, 1'b1, ev(3'd5, S_NONE, 2'b00, 3'b000, F_BUS, 16'd1), "bus_err_halt");

        do_reset("reset_clears_bus_err");
        fetch_decode(6'b100010, 16'd0, "sw2");
        step(6'b100010, 1'b0, 1'b1, ev(3'd2, S_IMM, 2'b00, 3'b100, F_OK, 16'd0), "sw2_exec");
        step(6'b100010, 1'b0, 1'b0, ev(3'd3, S_MEM_ST, 2'b00, 3'b100, F_OK, 16'd0), "sw2_mem");
        do_reset("reset_in_mem");
        step(6'b000000, 1'b0, 1'b1, ev(3'd0, S_F_OK, 2'b00, 3'b000, F_OK, 16'd0), "fetch_after_reset");
        step(6'b000000, 1'b0, 1'b1, ev(3'd1, S_NONE, 2'b00, 3'b000, F_OK, 16'd0), "decode_after_reset");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
